rc6_data_out_fifo: RTL and testbench

RC6_DATA_OUT_FIFO -- requirements
Module: rc6_data_out_fifo

---
 rtl/rc6_data_out_fifo_if.sv | 27 ++
 rtl/rc6_data_out_fifo.sv | 85 ++++++++
 tb/tb_rc6_data_out_fifo.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/rc6_data_out_fifo_if.sv
// Bus between the RC6 cipher core, the output FIFO and the downstream consumer.
// Handshake: a push is inWr with inData; a pop happens on any edge where outValid && inReady.
interface rc6_data_out_fifo_if #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              inWr;
    logic [DATA_W-1:0] inData;
    logic              inReady;
    logic              outValid;
    logic [DATA_W-1:0] outData;
    logic              outFull;
    logic [CNT_W-1:0]  outCount;
    logic              outOverflow;

    modport master (
        output inWr, inData, inReady,
        input  outValid, outData, outFull, outCount, outOverflow
    );

    modport slave (
        input  inWr, inData, inReady,
        output outValid, outData, outFull, outCount, outOverflow
    );
endinterface

// File: rtl/rc6_data_out_fifo.sv
// Show-ahead output FIFO for RC6 cipher results with a sticky overflow flag.
// Define RC6_OUT_BYTE_SWAP_EN to byte-reverse each 32-bit lane on write (NESSIE byte order).
module rc6_data_out_fifo #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 4
) (
    input  logic                 inClk,
    input  logic                 inReset,
    rc6_data_out_fifo_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              isEmpty;
    logic              isFull;
    logic              pop;
    logic              push;
    logic [DATA_W-1:0] storeData;

`ifdef RC6_OUT_BYTE_SWAP_EN
    function automatic logic [DATA_W-1:0] laneSwap(input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int lane = 0; lane < DATA_W / 32; lane++) begin
            for (int b = 0; b < 4; b++) begin
                r[lane*32 + b*8 +: 8] = d[lane*32 + (3-b)*8 +: 8];
            end
        end
        return r;
    endfunction

    assign storeData = laneSwap(bus.inData);
`else
    assign storeData = bus.inData;
`endif

    assign isEmpty = (count == '0);
    assign isFull  = (count == FULL_CNT);
    assign pop     = !isEmpty && bus.inReady;
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign push    = bus.inWr && (!isFull || pop);

    always_ff @(posedge inClk) begin
        if (inReset) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (bus.inWr && !push) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage is never cleared; reset only discards entries by resetting the pointers.
    always_ff @(posedge inClk) begin
        if (push && !inReset) begin
            mem[wrPtr] <= storeData;
        end
    end

    assign bus.outValid    = !isEmpty;
    assign bus.outData     = isEmpty ? '0 : mem[rdPtr];
    assign bus.outFull     = isFull;
    assign bus.outCount    = count;
    assign bus.outOverflow = overflow;
endmodule

// File: tb/tb_rc6_data_out_fifo.sv
// Randomized bench for rc6_data_out_fifo: a queue model is compared on every falling edge,
// plus directed scenarios pinned with literal expectations.
module tb_rc6_data_out_fifo;
    localparam int DATA_W = 128;
    localparam int DEPTH  = 4;

    logic inClk = 1'b0;
    logic inReset;

    rc6_data_out_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    rc6_data_out_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .inClk   (inClk),
        .inReset (inReset),
        .bus     (bus)
    );

    always #5 inClk = ~inClk;

    // Behavioural model: a plain queue of stored words plus the sticky flag.
    logic [DATA_W-1:0] modelQ[$];
    logic              modelOvf = 1'b0;
    bit                chkEn = 1'b0;
    int                nChecks = 0;
    int                nFails = 0;

    function automatic logic [DATA_W-1:0] expStore(input logic [DATA_W-1:0] d);
`ifdef RC6_OUT_BYTE_SWAP_EN
        logic [7:0] src [DATA_W/8];
        logic [DATA_W-1:0] r;
        for (int k = 0; k < DATA_W/8; k++) src[k] = d[k*8 +: 8];
        r = '0;
        for (int k = 0; k < DATA_W/8; k++) begin
            r[((k/4)*4 + (3 - k%4))*8 +: 8] = src[k];
        end
        return r;
`else
        return d;
`endif
    endfunction

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic modelUpdate(input logic rst, input logic wr, input logic [DATA_W-1:0] d, input logic rdy);
        bit popOk, full;
        if (rst) begin
            modelQ.delete();
            modelOvf = 1'b0;
        end else begin
            popOk = (modelQ.size() > 0) && rdy;
            full  = (modelQ.size() == DEPTH);
            if (popOk) void'(modelQ.pop_front());
            if (wr && (!full || popOk)) modelQ.push_back(expStore(d));
            else if (wr) modelOvf = 1'b1;
        end
    endtask

    // Drive inputs after a falling edge, let the rising edge happen, advance the model.
    task automatic step(input logic rst, input logic wr, input logic [DATA_W-1:0] d, input logic rdy);
        inReset     = rst;
        bus.inWr    = wr;
        bus.inData  = d;
        bus.inReady = rdy;
        @(posedge inClk);
        modelUpdate(rst, wr, d, rdy);
        @(negedge inClk);
        #1;
    endtask

    always @(negedge inClk) begin
        if (chkEn) begin
            chk("outValid", bus.outValid, (modelQ.size() > 0));
            chk("outData", bus.outData, (modelQ.size() > 0) ? modelQ[0] : '0);
            chk("outFull", bus.outFull, (modelQ.size() == DEPTH));
            chk("outCount", bus.outCount, modelQ.size());
            chk("outOverflow", bus.outOverflow, modelOvf);
        end
    end

    function automatic logic [DATA_W-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [DATA_W-1:0] words [5];
    logic [DATA_W-1:0] vecIn;
    logic [DATA_W-1:0] vecOut;

    initial begin
        inReset = 1'b1; bus.inWr = 1'b0; bus.inData = '0; bus.inReady = 1'b0;
        @(negedge inClk);
        step(1'b1, 1'b0, '0, 1'b0);
        chkEn = 1'b1;
        step(1'b1, 1'b1, rnd128(), 1'b1);
        chk("rst_valid", bus.outValid, 1'b0);
        chk("rst_count", bus.outCount, 3'd0);
        chk("rst_data", bus.outData, '0);

        // Known-answer vector for the lane byte order.
        vecIn = 128'h00112233_44556677_8899AABB_CCDDEEFF;
`ifdef RC6_OUT_BYTE_SWAP_EN
        vecOut = 128'h33221100_77665544_BBAA9988_FFEEDDCC;
`else
        vecOut = 128'h00112233_44556677_8899AABB_CCDDEEFF;
`endif
        step(1'b0, 1'b1, vecIn, 1'b0);
        chk("kat_valid", bus.outValid, 1'b1);
        chk("kat_data", bus.outData, vecOut);
        step(1'b0, 1'b0, '0, 1'b1);
        chk("kat_drained", bus.outValid, 1'b0);

        // Fill with ready low, drop the fifth push, then drain in order.
        for (int i = 0; i < 5; i++) words[i] = rnd128();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, words[i], 1'b0);
        chk("fill_full", bus.outFull, 1'b1);
        chk("fill_count", bus.outCount, 3'd4);
        chk("fill_ovf_clear", bus.outOverflow, 1'b0);
        step(1'b0, 1'b1, words[4], 1'b0);
        chk("drop_count", bus.outCount, 3'd4);
        chk("drop_ovf", bus.outOverflow, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("drain_order", bus.outData, expStore(words[i]));
            step(1'b0, 1'b0, '0, 1'b1);
        end
        chk("drain_empty", bus.outValid, 1'b0);
        chk("ovf_sticky", bus.outOverflow, 1'b1);

        // Full FIFO with simultaneous push and pop keeps count and does not overflow.
        step(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, words[i], 1'b0);
        step(1'b0, 1'b1, words[4], 1'b1);
        chk("pp_count", bus.outCount, 3'd4);
        chk("pp_ovf", bus.outOverflow, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1);
        chk("pp_new_word", bus.outData, expStore(words[4]));
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, '0, 1'b1);

        // Streaming push/pop across several pointer wraps.
        for (int i = 0; i < 3*DEPTH; i++) step(1'b0, 1'b1, rnd128(), 1'b1);
        chk("stream_count", bus.outCount, 3'd1);
        step(1'b0, 1'b0, '0, 1'b1);

        // Reset with two entries, overflow set and a push pending.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, rnd128(), 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        chk("pre_rst_count", bus.outCount, 3'd2);
        step(1'b1, 1'b1, rnd128(), 1'b0);
        chk("mid_rst_count", bus.outCount, 3'd0);
        chk("mid_rst_valid", bus.outValid, 1'b0);
        chk("mid_rst_data", bus.outData, '0);
        chk("mid_rst_ovf", bus.outOverflow, 1'b0);

        // Ready with nothing stored has no effect.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, rnd128(), 1'b1);
        chk("idle_count", bus.outCount, 3'd0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 99) < 60),
                 rnd128(),
                 ($urandom_range(0, 99) < 45));
        end

        chkEn = 1'b0;
        $display("%0d/%0d checks passed", nChecks - nFails, nChecks);
        $finish;
    end
endmodule
